fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
Fetch-side controller sitting directly upstream of the instruction-fetch stage. It owns the program counter and drives the PC into the fetch stage. It captures the returned instruction one cycle later and buffers {pc, inst} pairs in a small queue toward decode. It handles decode back-pressure and branch/jump redirects, sustaining one instruction per cycle when decode never stalls.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
PC_STEP, 32'd1, PC increment per issued fetch (PC is a word index into instruction memory).
QDEPTH, 2, number of {pc, inst} queue entries; supported range 2..4.

Ports:
clk  input  1  system clock.
rst  input  1  synchronous active-high reset.
fetch_pc  output  32  PC driven to the fetch stage; registered.
fetch_inst  input  32  instruction returned by the fetch stage; corresponds to fetch_pc issued in the previous cycle.
redirect_valid  input  1  branch/jump redirect request.
redirect_pc  input  32  redirect target.
id_ready  input  1  decode accepts the head entry this cycle.
id_valid  output  1  queue head valid.
id_pc  output  32  PC of the head entry.
id_inst  output  32  instruction of the head entry.

Behaviour:
- Single clock, clk. Reset is synchronous and active-high on rst. All state updates on posedge clk.
- State: pc_q (drives fetch_pc), inflight_q (1 bit, set when a fetch was issued last cycle), circular queue with head/tail pointers and count.
- Reset, asserted at any time including mid-stream:
  - pc_q = RESET_PC, inflight_q = 0, count = 0, pointers = 0.
  - id_valid = 0; id_pc = 0 and id_inst = 0.
  - The first cycle after reset release issues RESET_PC.
- pop = id_valid & id_ready. push = inflight_q (fetch_inst is captured with pc of the in-flight request, held in a 32-bit req_pc_q).
- Issue rule when redirect_valid = 0:
  - issue = (count + inflight_q - pop) < QDEPTH.
  - On issue: req_pc_q <= pc_q; pc_q <= pc_q + PC_STEP, modulo 2^32 (0xFFFF_FFFF + 1 = 0).
  - Without issue: pc_q holds and fetch_pc stays stable.
  - inflight_q <= issue.
- Queue update: count' = count + push - pop. Simultaneous push and pop leaves count unchanged. Push and pop never overflow or underflow given the issue rule; the bench asserts this.
- id_valid = (count != 0). id_pc and id_inst come from the head entry and read as 0 when empty. They are held stable while id_valid & !id_ready.
- Latency: a PC issued in cycle t is pushed at the end of t+1 and is first visible on id_* in cycle t+2. No bypass path.
- Throughput: with id_ready held at 1, one entry per cycle in steady state (count = 1, inflight_q = 1).
- Redirect, highest priority below rst. When redirect_valid = 1 in cycle t:
  - A pop in cycle t still completes; decode owns that entry.
  - All remaining queue entries are discarded (count <= 0), and the in-flight request is dropped (no push, inflight_q <= 0).
  - No issue in cycle t; pc_q <= redirect_pc.
  - Cycle t+1: id_valid = 0, fetch_pc = redirect_pc, issue proceeds.
  - The first redirected entry appears on id_* in cycle t+3.
- Back-to-back redirects: each one overrides the previous. Only the last target is fetched.

Test Plan:
- Bench model: fetch_inst(t+1) = ~fetch_pc(t).
- Reset then id_ready = 1 -> fetch_pc = 0,1,2,... per cycle. id_valid first high 2 cycles after release with id_pc = 0, id_inst = 0xFFFF_FFFF. Then consecutive pc every cycle, no bubbles.
- id_ready = 0 from reset -> fetches 0 and 1 issued; fetch_pc holds at 2; count = 2; id_pc = 0 stable. Raise id_ready -> id_pc sequence 0,1,2,3 with no gaps or duplicates.
- Queue full with id_ready = 0, then redirect_valid with redirect_pc = 0x40 for 1 cycle -> next cycle id_valid = 0 and fetch_pc = 0x40. id_pc = 0x40 with id_inst = ~0x40 two cycles later. Old entries never reappear.
- Redirect to 0x100 in the same cycle as an accepted handshake (id_pc = 5) -> pc 5 counted as consumed exactly once. Next delivered id_pc = 0x100.
- Redirect to 0xFFFF_FFFF, id_ready = 1 -> delivered id_pc = 0xFFFF_FFFF then 0x0000_0000.
- rst asserted for 1 cycle mid-stream with 2 entries queued -> next cycle id_valid = 0, fetch_pc = RESET_PC. Stream restarts from RESET_PC with no stale entries.

Source files
------------

// File: rtl/fetch_ctrl_if.sv
// Fetch-controller bus: PC/instruction exchange with the fetch stage
// plus the {pc, inst} handshake toward decode and the redirect request.
interface fetch_ctrl_if;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_inst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;

    modport master (
        output fetch_pc, id_valid, id_pc, id_inst,
        input  fetch_inst, redirect_valid, redirect_pc, id_ready
    );

    modport slave (
        input  fetch_pc, id_valid, id_pc, id_inst,
        output fetch_inst, redirect_valid, redirect_pc, id_ready
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch-side controller: owns the PC, captures returned instructions one cycle
// after issue and queues {pc, inst} pairs toward decode, with redirect flush.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd1,
    parameter int          QDEPTH   = 2
) (
    input  logic         clk,
    input  logic         rst,
    fetch_ctrl_if.master bus
);
    localparam int PW = (QDEPTH > 2) ? 2 : 1;
    localparam int CW = 3;

    logic [31:0]   pc_q, pc_d;
    logic [31:0]   req_pc_q, req_pc_d;
    logic          inflight_q, inflight_d;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   q_pc_q [QDEPTH];
    logic [31:0]   q_pc_d [QDEPTH];
    logic [31:0]   q_inst_q [QDEPTH];
    logic [31:0]   q_inst_d [QDEPTH];

    logic          id_valid;
    logic          pop;
    logic          push;
    logic          issue;
    logic [3:0]    occ;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(QDEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign id_valid = (count_q != '0);

    always_comb begin
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        inflight_d = inflight_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        q_pc_d     = q_pc_q;
        q_inst_d   = q_inst_q;

        pop  = id_valid & bus.id_ready;
        // A redirect drops the in-flight return; a pop in the same cycle still counts.
        push = inflight_q & ~bus.redirect_valid;
        occ  = {1'b0, count_q} + {3'b000, inflight_q} - {3'b000, pop};
        issue = ~bus.redirect_valid & (occ < 4'(QDEPTH));

        if (push) begin
            q_pc_d[tail_q]   = req_pc_q;
            q_inst_d[tail_q] = bus.fetch_inst;
            tail_d           = ptr_inc(tail_q);
        end
        if (pop) begin
            head_d = ptr_inc(head_q);
        end

        if (bus.redirect_valid) begin
            count_d    = '0;
            head_d     = '0;
            tail_d     = '0;
            inflight_d = 1'b0;
            pc_d       = bus.redirect_pc;
        end else begin
            count_d    = count_q + CW'(push) - CW'(pop);
            inflight_d = issue;
            if (issue) begin
                req_pc_d = pc_q;
                pc_d     = pc_q + PC_STEP;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            q_pc_q     <= q_pc_d;
            q_inst_q   <= q_inst_d;
        end
    end

    assign bus.fetch_pc = pc_q;
    assign bus.id_valid = id_valid;
    assign bus.id_pc    = id_valid ? q_pc_q[head_q]   : 32'h0;
    assign bus.id_inst  = id_valid ? q_inst_q[head_q] : 32'h0;
endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl; the instruction memory returns ~pc one cycle
// after the PC is driven.
module tb_fetch_ctrl;
    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic [31:0] pc_prev;

    fetch_ctrl_if bus();

    fetch_ctrl #(
        .RESET_PC(32'h0000_0000),
        .PC_STEP (32'd1),
        .QDEPTH  (2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // One clock; inputs and the memory return change 1 time unit after the edge.
    task automatic tick();
        pc_prev = bus.fetch_pc;
        @(posedge clk);
        #1;
        bus.fetch_inst = ~pc_prev;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_id(input string tag, input logic [31:0] pc);
        chk({tag, "_valid"}, 32'(bus.id_valid), 32'd1);
        chk({tag, "_pc"}, bus.id_pc, pc);
        chk({tag, "_inst"}, bus.id_inst, ~pc);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        checks = 0;
        errors = 0;
        pc_prev = '0;
        bus.fetch_inst     = '0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.id_ready       = 1'b0;
        repeat (2) tick();

        chk("rst_fetch_pc", bus.fetch_pc, 32'h0);
        chk("rst_id_valid", 32'(bus.id_valid), 32'd0);
        chk("rst_id_pc", bus.id_pc, 32'h0);
        chk("rst_id_inst", bus.id_inst, 32'h0);

        // Streaming from reset, decode always ready.
        rst = 1'b0;
        bus.id_ready = 1'b1;
        chk("s_c0_fetch_pc", bus.fetch_pc, 32'd0);
        chk("s_c0_valid", 32'(bus.id_valid), 32'd0);
        tick();
        chk("s_c1_fetch_pc", bus.fetch_pc, 32'd1);
        chk("s_c1_valid", 32'(bus.id_valid), 32'd0);
        tick();
        chk("s_c2_fetch_pc", bus.fetch_pc, 32'd2);
        chk_id("s_c2", 32'd0);
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk_id("s_stream", 32'(k));
            chk("s_stream_fetch_pc", bus.fetch_pc, 32'(k + 2));
        end

        // Decode stalled from reset: queue fills with pcs 0 and 1.
        rst = 1'b1;
        bus.id_ready = 1'b0;
        tick();
        rst = 1'b0;
        repeat (3) tick();
        chk("st_c3_fetch_pc", bus.fetch_pc, 32'd2);
        chk_id("st_c3", 32'd0);
        tick();
        chk("st_c4_fetch_pc", bus.fetch_pc, 32'd2);
        bus.id_ready = 1'b1;
        for (int i = 0; i <= 5; i++) begin
            chk_id("st_drain", 32'(i));
            tick();
        end

        // Fill the queue, then redirect to 0x40.
        bus.id_ready = 1'b0;
        repeat (4) tick();
        chk("rd_full_fetch_pc", bus.fetch_pc, 32'd8);
        chk_id("rd_full_head", 32'd6);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h40;
        tick();
        bus.redirect_valid = 1'b0;
        bus.id_ready       = 1'b1;
        chk("rd_t1_valid", 32'(bus.id_valid), 32'd0);
        chk("rd_t1_fetch_pc", bus.fetch_pc, 32'h40);
        chk("rd_t1_id_pc", bus.id_pc, 32'h0);
        tick();
        chk("rd_t2_valid", 32'(bus.id_valid), 32'd0);
        chk("rd_t2_fetch_pc", bus.fetch_pc, 32'h41);
        tick();
        chk_id("rd_t3", 32'h40);
        chk("rd_t3_fetch_pc", bus.fetch_pc, 32'h42);
        tick();
        chk_id("rd_t4", 32'h41);
        tick();
        chk_id("rd_t5", 32'h42);

        // Redirect coinciding with an accepted handshake at pc 5.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (7) tick();
        chk_id("hs_pc5", 32'd5);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h100;
        tick();
        bus.redirect_valid = 1'b0;
        chk("hs_t1_valid", 32'(bus.id_valid), 32'd0);
        chk("hs_t1_fetch_pc", bus.fetch_pc, 32'h100);
        tick();
        chk("hs_t2_valid", 32'(bus.id_valid), 32'd0);
        tick();
        chk_id("hs_t3", 32'h100);
        tick();
        chk_id("hs_t4", 32'h101);

        // Redirect to the top of the address space; PC wraps to 0.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFF;
        tick();
        bus.redirect_valid = 1'b0;
        chk("wr_t1_fetch_pc", bus.fetch_pc, 32'hFFFF_FFFF);
        chk("wr_t1_valid", 32'(bus.id_valid), 32'd0);
        tick();
        chk("wr_t2_fetch_pc", bus.fetch_pc, 32'h0);
        tick();
        chk_id("wr_t3", 32'hFFFF_FFFF);
        tick();
        chk_id("wr_t4", 32'h0);
        tick();
        chk_id("wr_t5", 32'h1);

        // Back-to-back redirects: only the second target is fetched.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h200;
        tick();
        bus.redirect_pc    = 32'h300;
        chk("bb_b_fetch_pc", bus.fetch_pc, 32'h200);
        tick();
        bus.redirect_valid = 1'b0;
        chk("bb_c_fetch_pc", bus.fetch_pc, 32'h300);
        chk("bb_c_valid", 32'(bus.id_valid), 32'd0);
        tick();
        chk("bb_d_valid", 32'(bus.id_valid), 32'd0);
        tick();
        chk_id("bb_e", 32'h300);

        // Mid-stream reset with two entries queued.
        bus.id_ready = 1'b0;
        repeat (3) tick();
        chk("mr_full_fetch_pc", bus.fetch_pc, 32'h302);
        chk_id("mr_full_head", 32'h300);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.id_ready = 1'b1;
        chk("mr_t1_valid", 32'(bus.id_valid), 32'd0);
        chk("mr_t1_fetch_pc", bus.fetch_pc, 32'h0);
        chk("mr_t1_id_pc", bus.id_pc, 32'h0);
        tick();
        chk("mr_t2_fetch_pc", bus.fetch_pc, 32'h1);
        chk("mr_t2_valid", 32'(bus.id_valid), 32'd0);
        tick();
        chk_id("mr_t3", 32'h0);
        tick();
        chk_id("mr_t4", 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
